// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one fixed-latency memory port between I and D caches
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_web,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_BUSY     = 2'd1;
  localparam logic [1:0] c_ACK      = 2'd2;
  localparam logic [2:0] c_LAT_LAST = 3'(MEM_LAT - 1);
  localparam logic [3:0] c_STARVE   = 4'(STARVE_MAX);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_d_q, owner_d_d;   // 1 = data cache owns the transaction
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        w_grant_i;

  // D normally wins; a pending I wins once D has been granted STARVE_MAX times in a row
  assign w_grant_i = i_req && (!d_req || (starve_q == c_STARVE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    owner_d_d = owner_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      c_IDLE: begin
        if (i_req || d_req) begin
          state_d = c_BUSY;
          cnt_d   = 3'd0;
          if (w_grant_i) begin
            owner_d_d = 1'b0;
            we_d      = 1'b0;
            addr_d    = i_addr;
            wdata_d   = 32'd0;
            starve_d  = 4'd0;
          end else begin
            owner_d_d = 1'b1;
            we_d      = d_we;
            addr_d    = d_addr;
            wdata_d   = d_wdata;
            if (!i_req)
              starve_d = 4'd0;
            else if (starve_q != c_STARVE)
              starve_d = starve_q + 4'd1;
          end
        end
      end
      c_BUSY: begin
        if (we_q) begin
          state_d = c_ACK;
        end else if (cnt_q == c_LAT_LAST) begin
          state_d = c_ACK;
          if (owner_d_q)
            d_rdata_d = mem_rdata;
          else
            i_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      c_ACK:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_IDLE;
      cnt_q     <= 3'd0;
      starve_q  <= 4'd0;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      owner_d_q <= owner_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Memory-side outputs are decoded from registered state only
  assign mem_addr  = (state_q == c_BUSY) ? addr_q : 32'd0;
  assign mem_wdata = ((state_q == c_BUSY) && we_q) ? wdata_q : 32'd0;
  assign mem_web   = (state_q == c_BUSY) && we_q;
  assign i_ack     = (state_q == c_ACK) && !owner_d_q;
  assign d_ack     = (state_q == c_ACK) && owner_d_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != c_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the instruction cache (read-only refills) and the data cache (read refills, dirty write-backs, uncached MMIO accesses). Sits between both caches and the unified memory/MMIO bus. Sequences each access with a fixed read latency, returns data with a one-cycle acknowledge, and prevents instruction-fetch starvation under sustained data traffic.

## Interface
- MEM_LAT, 2: cycles from `mem_addr` presented to `mem_rdata` valid; legal range 1..7.
- STARVE_MAX, 4: consecutive D grants allowed while `i_req` is pending; legal range 1..15.

- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  icache read request; held until `i_ack`.
- i_addr  in  32  icache byte address; stable while `i_req` is high.
- i_rdata  out  32  read data; valid only in the `i_ack` cycle.
- i_ack  out  1  one-cycle completion pulse.
- d_req  in  1  dcache request; held until `d_ack`.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  dcache byte address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data; valid only in the `d_ack` cycle.
- d_ack  out  1  one-cycle completion pulse.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_web  out  1  memory write enable.
- mem_rdata  in  32  memory read data.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - BUSY: transaction in flight.
  - ACK: pulse the acknowledge.
- IDLE:
  - If any request is pending, latch owner, address, `we` and wdata, clear `cnt`, and go to BUSY.
  - With no request, stay in IDLE.
- Arbitration priority is D over I, with one exception: I wins when `i_req` is high and `starve_cnt == STARVE_MAX`.
- `starve_cnt` (4 bits):
  - Increments on a D grant while `i_req` is high.
  - Clears on any I grant.
  - Clears on any D grant while `i_req` is low.
  - Saturates at STARVE_MAX.
- BUSY:
  - `mem_addr` = latched address. No alignment or masking is applied; MMIO addresses pass through unchanged.
  - Read: `cnt` counts 0..MEM_LAT-1. In the cycle `cnt == MEM_LAT-1`, `mem_rdata` is captured into the owner's rdata register, then the FSM goes to ACK.
  - Write: `mem_web = 1` and `mem_wdata` = latched wdata for exactly one cycle (the single BUSY cycle), then the FSM goes to ACK. The owner's rdata register is unchanged.
- ACK:
  - The owner's ack is 1 for one cycle.
  - No request is sampled in this cycle, because the requester still holds req.
  - Next state is IDLE.
- Outside BUSY: `mem_addr = 0`, `mem_wdata = 0`, `mem_web = 0`.
- `i_ack` and `d_ack` are never high together. `i_ack` is never raised for a write.
- Illegal input: a requester drops req before its ack. The arbiter still completes the transaction and pulses the ack, which is ignored.

## Timing
- Request sampled at the posedge ending cycle 0.
- Read: BUSY occupies cycles 1..MEM_LAT; ack in cycle MEM_LAT+1. Default latency is 3 cycles from req to ack.
- Write: BUSY in cycle 1 with `mem_web = 1`; ack in cycle 2.
- Back-to-back: a request held or raised in the cycle after ACK is sampled in that cycle. Minimum spacing is MEM_LAT+2 cycles per read and 3 cycles per write.
- Simultaneous `i_req`/`d_req` in IDLE: arbitration rule above. The loser is served at the next IDLE.
- Reset values:
  - state IDLE, `cnt = 0`, `starve_cnt = 0`.
  - `i_ack = d_ack = 0`, `i_rdata = d_rdata = 0`, `busy = 0`.
  - `mem_addr = 0`, `mem_wdata = 0`, `mem_web = 0`.
- Reset mid-transaction:
  - The transaction is abandoned; no ack is ever issued for it.
  - A write whose `mem_web` cycle already occurred stays committed.
  - The first request is sampled in the first cycle after `rst` falls.
- All outputs are registered or decoded from registered state. No combinational path exists from `*_req` to `mem_*` or to the acks.

## Test plan
- Single I read, MEM_LAT = 2:
  - Stimulus: `i_req = 1`, `i_addr = 0x0000_0040` at cycle 0; memory returns `0xDEAD_BEEF`.
  - Required: `mem_addr = 0x40` in cycles 1–2, `i_ack = 1` with `i_rdata = 0xDEAD_BEEF` in cycle 3, `busy` high in cycles 1–3.
- D write:
  - Stimulus: `d_we = 1`, `d_addr = 0x000F_FC00`, `d_wdata = 0x1234_5678`.
  - Required: exactly one `mem_web` cycle carrying that address/data, `d_ack` in cycle 2, `d_rdata` unchanged.
- Simultaneous requests:
  - Stimulus: `i_req` and `d_req` (read) both raised in cycle 0.
  - Required: D acked in cycle 3; I sampled in cycle 4 and acked in cycle 7.
- Starvation, STARVE_MAX = 4:
  - Stimulus: `d_req` held continuously with back-to-back reads; `i_req` held continuously.
  - Required: exactly 4 `d_ack`s, then one `i_ack`, then D resumes; the pattern repeats.
- Reset mid-read:
  - Stimulus: assert `rst` in cycle 2 of a D read.
  - Required: no `d_ack`; all outputs 0 in the cycle after the reset edge; a new I read issued after reset completes normally.
- MEM_LAT = 1 build:
  - Stimulus: a read request.
  - Required: ack in cycle 2; repeat the simultaneous-request scenario with the latencies scaled accordingly.
